// File: rtl/array_feed_buffer.sv
// Eight-word payload buffer that streams words to the delivery stage on pointer-advance pulses,
// then drains for DRAIN_CYC cycles before a one-cycle done pulse.
module array_feed_buffer #(
  parameter int unsigned W         = 32,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         start,
  input  logic [3:0]   len,
  input  logic         abort,
  input  logic         master_rptr_en,
  output logic         select,
  output logic [W-1:0] data,
  output logic [2:0]   rptr,
  output logic         busy,
  output logic         done,
  output logic         wr_err
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t       state;
  logic [W-1:0] mem [8];
  logic [3:0]   len_q;
  logic [3:0]   drain_cnt;
  logic         wr_ok;
  logic         last_word;

  assign wr_ok     = (state == IDLE) || (state == DONE);
  assign last_word = ({1'b0, rptr} == (len_q - 4'd1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 8; i++) mem[i] <= '0;
    end else if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // select is registered and high only in STREAM, so it doubles as the data qualifier
  always_comb begin
    data = '0;
    if (select) data = mem[rptr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rptr      <= '0;
      len_q     <= '0;
      drain_cnt <= '0;
      select    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      done   <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        rptr   <= '0;
        select <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rptr <= '0;
              if (len == 4'd0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                len_q  <= (len > 4'd8) ? 4'd8 : len;
                state  <= STREAM;
                select <= 1'b1;
                busy   <= 1'b1;
              end
            end
          end
          STREAM: begin
            if (master_rptr_en) begin
              if (last_word) begin
                state     <= DRAIN;
                drain_cnt <= 4'(DRAIN_CYC);
                select    <= 1'b0;
              end else begin
                rptr <= rptr + 3'd1;
              end
            end
          end
          DRAIN: begin
            if (drain_cnt <= 4'd1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 4'd1;
            end
          end
          DONE: begin
            state <= IDLE;
            rptr  <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_array_feed_buffer.sv
// Randomized self-checking bench for array_feed_buffer against a word-array reference model.
module tb_array_feed_buffer;
  localparam int unsigned W         = 32;
  localparam int unsigned DRAIN_CYC = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         start;
  logic [3:0]   len;
  logic         abort;
  logic         master_rptr_en;
  logic         select;
  logic [W-1:0] data;
  logic [2:0]   rptr;
  logic         busy;
  logic         done;
  logic         wr_err;

  logic [W-1:0] ref_mem [8];
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;

  array_feed_buffer #(.W(W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .abort(abort), .master_rptr_en(master_rptr_en),
    .select(select), .data(data), .rptr(rptr), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic load_random();
    for (int unsigned a = 0; a < 8; a++) host_write(3'(a), $urandom);
  endtask

  // Streams n words with random or zero pulse gaps; expected timing derives from n and DRAIN_CYC.
  task automatic run_stream(input int unsigned n, input bit hold_en);
    int unsigned eff;
    int unsigned gap;
    eff = (n > 8) ? 8 : n;
    start = 1'b1; len = 4'(n);
    step();
    start = 1'b0;
    if (eff == 0) begin
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_len_done got %b exp 1", done); end
      vectors++; if (select !== 1'b0) begin miscompares++; $display("FAIL zero_len_select got %b exp 0", select); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_len_busy got %b exp 0", busy); end
      step();
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zero_len_done_end got %b exp 0", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_len_busy_end got %b exp 0", busy); end
      return;
    end
    for (int unsigned i = 0; i < eff; i++) begin
      gap = hold_en ? 0 : $urandom_range(2, 0);
      for (int unsigned g = 0; g <= gap; g++) begin
        vectors++; if (select !== 1'b1) begin miscompares++; $display("FAIL stream_select word %0d got %b exp 1", i, select); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stream_busy word %0d got %b exp 1", i, busy); end
        vectors++; if (rptr !== 3'(i)) begin miscompares++; $display("FAIL stream_rptr got %0d exp %0d", rptr, i); end
        vectors++; if (data !== ref_mem[i]) begin miscompares++; $display("FAIL stream_data word %0d got %h exp %h", i, data, ref_mem[i]); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL stream_done word %0d got %b exp 0", i, done); end
        master_rptr_en = (g == gap);
        step();
      end
      if (!hold_en) master_rptr_en = 1'b0;
    end
    for (int unsigned c = 0; c < DRAIN_CYC; c++) begin
      vectors++; if (select !== 1'b0) begin miscompares++; $display("FAIL drain_select cyc %0d got %b exp 0", c, select); end
      vectors++; if (data !== '0) begin miscompares++; $display("FAIL drain_data cyc %0d got %h exp 0", c, data); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drain_busy cyc %0d got %b exp 1", c, busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL drain_done cyc %0d got %b exp 0", c, done); end
      vectors++; if (rptr !== 3'(eff - 1)) begin miscompares++; $display("FAIL drain_rptr cyc %0d got %0d exp %0d", c, rptr, eff - 1); end
      step();
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL done_pulse got %b exp 1", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_busy got %b exp 0", busy); end
    vectors++; if (select !== 1'b0) begin miscompares++; $display("FAIL done_select got %b exp 0", select); end
    master_rptr_en = 1'b0;
    step();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_width got %b exp 0", done); end
    vectors++; if (rptr !== 3'd0) begin miscompares++; $display("FAIL idle_rptr got %0d exp 0", rptr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset();
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    len = '0; abort = 1'b0; master_rptr_en = 1'b0;
    for (int unsigned a = 0; a < 8; a++) ref_mem[a] = '0;
    #12;
    vectors++; if (select !== 1'b0) begin miscompares++; $display("FAIL reset_select got %b exp 0", select); end
    vectors++; if (data !== '0) begin miscompares++; $display("FAIL reset_data got %h exp 0", data); end
    vectors++; if (rptr !== 3'd0) begin miscompares++; $display("FAIL reset_rptr got %0d exp 0", rptr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
    vectors++; if (wr_err !== 1'b0) begin miscompares++; $display("FAIL reset_wr_err got %b exp 0", wr_err); end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic_stream();
    host_write(3'd0, 32'h11); host_write(3'd1, 32'h22);
    host_write(3'd2, 32'h33); host_write(3'd3, 32'h44);
    for (int unsigned a = 4; a < 8; a++) host_write(3'(a), $urandom);
    run_stream(4, 1'b0);
    load_random();
    run_stream($urandom_range(8, 1), 1'b0);
  endtask

  task automatic test_back_to_back();
    load_random();
    run_stream(8, 1'b1);
  endtask

  task automatic test_len_edges();
    run_stream(0, 1'b0);
    run_stream(12, 1'b0);
    run_stream($urandom_range(15, 9), 1'b1);
    run_stream(1, 1'b0);
  endtask

  task automatic test_write_reject();
    logic [W-1:0] d;
    load_random();
    d = ~ref_mem[2];
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = d;
    step();
    wr_en = 1'b0;
    vectors++; if (wr_err !== 1'b1) begin miscompares++; $display("FAIL wr_err_pulse got %b exp 1", wr_err); end
    step();
    vectors++; if (wr_err !== 1'b0) begin miscompares++; $display("FAIL wr_err_width got %b exp 0", wr_err); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    run_stream(8, 1'b0);
  endtask

  task automatic test_write_with_start();
    logic [W-1:0] d;
    d = $urandom;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = d; start = 1'b1; len = 4'd1;
    step();
    wr_en = 1'b0; start = 1'b0;
    ref_mem[0] = d;
    vectors++; if (data !== d) begin miscompares++; $display("FAIL write_start_data got %h exp %h", data, d); end
    vectors++; if (wr_err !== 1'b0) begin miscompares++; $display("FAIL write_start_wr_err got %b exp 0", wr_err); end
    master_rptr_en = 1'b1;
    step();
    master_rptr_en = 1'b0;
    repeat (DRAIN_CYC) step();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL write_start_done got %b exp 1", done); end
    step();
  endtask

  task automatic test_abort();
    load_random();
    start = 1'b1; len = 4'd8;
    step();
    start = 1'b0;
    master_rptr_en = 1'b1;
    repeat (3) step();
    master_rptr_en = 1'b0;
    vectors++; if (rptr !== 3'd3) begin miscompares++; $display("FAIL abort_pre_rptr got %0d exp 3", rptr); end
    vectors++; if (data !== ref_mem[3]) begin miscompares++; $display("FAIL abort_pre_data got %h exp %h", data, ref_mem[3]); end
    abort = 1'b1; master_rptr_en = 1'b1;
    step();
    abort = 1'b0; master_rptr_en = 1'b0;
    vectors++; if (select !== 1'b0) begin miscompares++; $display("FAIL abort_select got %b exp 0", select); end
    vectors++; if (rptr !== 3'd0) begin miscompares++; $display("FAIL abort_rptr got %0d exp 0", rptr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp 0", busy); end
    vectors++; if (data !== '0) begin miscompares++; $display("FAIL abort_data got %h exp 0", data); end
    for (int unsigned c = 0; c < DRAIN_CYC + 2; c++) begin
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done cyc %0d got %b exp 0", c, done); end
      step();
    end
    abort = 1'b1; start = 1'b1; len = 4'd5;
    step();
    abort = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_over_start_busy got %b exp 0", busy); end
    vectors++; if (select !== 1'b0) begin miscompares++; $display("FAIL abort_over_start_select got %b exp 0", select); end
    run_stream($urandom_range(8, 1), 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    load_random();
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0;
    master_rptr_en = 1'b1;
    repeat (2) step();
    master_rptr_en = 1'b0;
    step();
    #2 resetn = 1'b0;
    #1;
    for (int unsigned a = 0; a < 8; a++) ref_mem[a] = '0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy got %b exp 0", busy); end
    vectors++; if (rptr !== 3'd0) begin miscompares++; $display("FAIL async_reset_rptr got %0d exp 0", rptr); end
    vectors++; if (select !== 1'b0) begin miscompares++; $display("FAIL async_reset_select got %b exp 0", select); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL async_reset_done got %b exp 0", done); end
    @(negedge clk);
    resetn = 1'b1;
    step();
    run_stream(8, 1'b0);
    load_random();
    run_stream($urandom_range(8, 1), 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_back_to_back();
    test_len_edges();
    test_write_reject();
    test_write_with_start();
    test_abort();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/array_feed_buffer.md
# array_feed_buffer

Upstream feeder for the data delivery subsystem. Holds up to eight W-bit payload words loaded by the host, then streams them one word at a time into the delivery stage. It drives the delivery stage's `select`, `data` and `rptr_in` inputs, and advances its read pointer only when the delivery stage pulses `master_rptr_en`. A drain interval after the last word lets the aligner FIFOs settle before `done` is raised.

## Interface
Parameters:
- `W`, 32, payload word width.
- `DRAIN_CYC`, 4, cycles spent in DRAIN after the last pointer advance (1..15).

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous assert, active low.
- `wr_en`  in  1  host write strobe.
- `wr_addr`  in  3  host write address.
- `wr_data`  in  W  host write data.
- `start`  in  1  single-cycle pulse that begins a stream.
- `len`  in  4  number of words to stream; sampled when `start` is accepted; legal range 0..8.
- `abort`  in  1  synchronous abort.
- `master_rptr_en`  in  1  pointer-advance pulse from the delivery stage.
- `select`  out  1  stream-active qualifier to the delivery stage.
- `data`  out  W  current payload word, `mem[rptr]`.
- `rptr`  out  3  current read pointer, wired to the delivery stage's `rptr_in`.
- `busy`  out  1  high in STREAM and DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `wr_err`  out  1  one-cycle pulse when a write is rejected.

## Operation
- Storage: 8×W register file. Reset clears all entries to 0.
- Writes:
  - Accepted in IDLE and DONE: `mem[wr_addr] <= wr_data`.
  - Rejected in STREAM and DRAIN: memory unchanged, `wr_err` pulses the next cycle.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - `start` with `len` in 1..8: latch `len_q`, set `rptr <= 0`, go to STREAM.
  - `start` with `len = 0`: go directly to DONE.
  - `start` with `len > 8`: `len_q` saturates to 8.
- STREAM:
  - `select = 1`. `data = mem[rptr]`, combinational from registers.
  - On `master_rptr_en`:
    - if `rptr == len_q-1`: go to DRAIN, load the drain counter with `DRAIN_CYC`, hold `rptr`.
    - otherwise: `rptr <= rptr+1`.
  - `rptr` never wraps. With `len_q = 8` the last word is at `rptr = 7`.
- DRAIN: `select = 0`. The counter decrements each cycle. When it reaches 1, go to DONE.
- DONE: `done = 1` for exactly this one cycle, then return to IDLE. `rptr` returns to 0 on entry to IDLE.
- Outputs outside STREAM: `data = 0`.
- Ignored inputs:
  - `start` outside IDLE is ignored.
  - `master_rptr_en` outside STREAM is ignored.
- `abort`:
  - In any state, forces IDLE on the next edge with `rptr = 0` and `select = 0`.
  - No `done` pulse. Memory is retained.
  - `abort` takes priority over `start` and `master_rptr_en` in the same cycle.
- Write and start in the same IDLE cycle: the write commits at that edge, so the first STREAM cycle presents the new value.

## Timing
- Reset values: `select = 0`, `data = 0`, `rptr = 0`, `busy = 0`, `done = 0`, `wr_err = 0`, state IDLE.
- Start latency: `start` accepted at edge k → `select = 1` and `data = mem[0]` valid in cycle k+1.
- Advance latency: `master_rptr_en` high at edge k → new `rptr` and `data` valid in cycle k+1. Back-to-back pulses advance one word per cycle.
- Total DRAIN length: exactly `DRAIN_CYC` cycles. `done` is asserted in the cycle immediately after DRAIN.
- Zero-length stream: `start` at edge k with `len = 0` → `done` in cycle k+1. `busy` never rises.
- `busy` is a registered state decode: high from cycle k+1 through the last DRAIN cycle.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronous).

## Test plan
- Load `mem[0..3] = 0x11,0x22,0x33,0x44`, `start` with `len = 4`, pulse `master_rptr_en` every other cycle → `data` sequence 0x11, 0x22, 0x33, 0x44 with `rptr` 0..3. `select` drops after the 4th pulse. `done` pulses exactly `DRAIN_CYC + 1` cycles after that pulse.
- `len = 8`, `master_rptr_en` held high continuously → `rptr` runs 0..7, one step per cycle, never wraps to 0 while `select = 1`. Extra pulses during DRAIN leave `rptr` at 7.
- `len = 0` → `done` the cycle after `start`, `select` never rises. `len = 12` → exactly 8 words streamed.
- `wr_en` to address 2 during STREAM → `wr_err` pulses and `mem[2]` is unchanged on the next stream. Same-cycle `wr_en` + `start` → the new `mem[0]` appears in the first STREAM cycle.
- `abort` in STREAM at `rptr = 3` together with `master_rptr_en` → next cycle IDLE, `rptr = 0`, `select = 0`, no `done`. A subsequent `start` restreams from word 0.
- `resetn` low mid-DRAIN → all outputs 0 asynchronously and memory cleared. After release, `start` is accepted normally.
